// File: rtl/writeback_regfile_if.sv
// MEM/WB-to-register-file bus: write-back inputs, decode read ports and commit trace.
// The slave modport is the register file; the master modport is the pipeline side.
interface writeback_regfile_if;
  logic [31:0] PCAddResult;
  logic [31:0] MemReadData;
  logic [31:0] ALUResult;
  logic [4:0]  RegRd;
  logic        RegWrite;
  logic        MemToReg;
  logic        Jal;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] WriteData;
  logic [4:0]  LastWriteReg;
  logic [31:0] LastWriteData;
  logic [31:0] CommitCount;

  modport slave (
    input  PCAddResult, MemReadData, ALUResult, RegRd, RegWrite, MemToReg, Jal,
    input  ReadRegister1, ReadRegister2,
    output ReadData1, ReadData2, WriteData, LastWriteReg, LastWriteData, CommitCount
  );

  modport master (
    output PCAddResult, MemReadData, ALUResult, RegRd, RegWrite, MemToReg, Jal,
    output ReadRegister1, ReadRegister2,
    input  ReadData1, ReadData2, WriteData, LastWriteReg, LastWriteData, CommitCount
  );
endinterface

// File: rtl/writeback_regfile.sv
// Write-back select, 32x32 register file with two combinational read ports, and commit trace.
// Optional macro WB_BYPASS_EN: same-cycle write-through from the committing value to the read ports.
module writeback_regfile (
  input logic                i_clk,
  input logic                i_reset,
  writeback_regfile_if.slave wb
);
  localparam int unsigned DataW   = 32;
  localparam int unsigned AddrW   = 5;
  localparam int unsigned NumRegs = 32;
  localparam logic [AddrW-1:0] LinkReg = AddrW'(31);

  logic [DataW-1:0] r_regs [NumRegs];
  logic [AddrW-1:0] r_last_reg;
  logic [DataW-1:0] r_last_data;
  logic [DataW-1:0] r_commit_count;

  logic [AddrW-1:0] w_dest;
  logic [DataW-1:0] w_wdata;
  logic             w_commit;
  logic [DataW-1:0] w_rd1;
  logic [DataW-1:0] w_rd2;

  // Link writes override both the destination and the data source.
  always_comb begin
    w_dest  = wb.RegRd;
    w_wdata = wb.ALUResult;
    if (wb.Jal) begin
      w_dest  = LinkReg;
      w_wdata = wb.PCAddResult;
    end else if (wb.MemToReg) begin
      w_wdata = wb.MemReadData;
    end
  end

  // Reset gate is the only guard against undefined MEM/WB contents while the pipe refills.
  assign w_commit = (wb.RegWrite | wb.Jal) & ~i_reset & (w_dest != '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < int'(NumRegs); i++) begin
        r_regs[i] <= '0;
      end
      r_last_reg     <= '0;
      r_last_data    <= '0;
      r_commit_count <= '0;
    end else if (w_commit) begin
      r_regs[w_dest] <= w_wdata;
      r_last_reg     <= w_dest;
      r_last_data    <= w_wdata;
      r_commit_count <= r_commit_count + DataW'(1);
    end
  end

  // Register 0 is hardwired to zero on read; a commit to it never happens.
  always_comb begin
    w_rd1 = (wb.ReadRegister1 == '0) ? '0 : r_regs[wb.ReadRegister1];
    w_rd2 = (wb.ReadRegister2 == '0) ? '0 : r_regs[wb.ReadRegister2];
`ifdef WB_BYPASS_EN
    if (w_commit && (wb.ReadRegister1 == w_dest)) w_rd1 = w_wdata;
    if (w_commit && (wb.ReadRegister2 == w_dest)) w_rd2 = w_wdata;
`endif
  end

  assign wb.ReadData1     = w_rd1;
  assign wb.ReadData2     = w_rd2;
  assign wb.WriteData     = w_wdata;
  assign wb.LastWriteReg  = r_last_reg;
  assign wb.LastWriteData = r_last_data;
  assign wb.CommitCount   = r_commit_count;
endmodule

// File: tb/tb_writeback_regfile.sv
// Directed and randomized bench for writeback_regfile against an array-based architectural model.
module tb_writeback_regfile;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [31:0] m_regs [32];
  logic [31:0] m_count;
  logic [4:0]  m_last_reg;
  logic [31:0] m_last_data;

  writeback_regfile_if wb_if ();

  writeback_regfile dut (
    .i_clk   (clk),
    .i_reset (reset),
    .wb      (wb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic rw, input logic jal, input logic m2r, input logic [4:0] rd,
                       input logic [31:0] pc, input logic [31:0] mem, input logic [31:0] alu);
    wb_if.RegWrite    = rw;
    wb_if.Jal         = jal;
    wb_if.MemToReg    = m2r;
    wb_if.RegRd       = rd;
    wb_if.PCAddResult = pc;
    wb_if.MemReadData = mem;
    wb_if.ALUResult   = alu;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  function automatic logic [4:0] exp_dest();
    return wb_if.Jal ? 5'd31 : wb_if.RegRd;
  endfunction

  function automatic logic [31:0] exp_wdata();
    if (wb_if.Jal) return wb_if.PCAddResult;
    return wb_if.MemToReg ? wb_if.MemReadData : wb_if.ALUResult;
  endfunction

  function automatic logic exp_commit();
    return (wb_if.RegWrite || wb_if.Jal) && !reset && (exp_dest() != 5'd0);
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    logic [31:0] v;
    v = (a == 5'd0) ? 32'd0 : m_regs[a];
`ifdef WB_BYPASS_EN
    if (exp_commit() && (a == exp_dest())) v = exp_wdata();
`endif
    return v;
  endfunction

  // Architectural effect of one clock edge given the inputs currently applied.
  task automatic tick();
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_count     = 32'd0;
      m_last_reg  = 5'd0;
      m_last_data = 32'd0;
    end else if (exp_commit()) begin
      m_regs[exp_dest()] = exp_wdata();
      m_last_reg         = exp_dest();
      m_last_data        = exp_wdata();
      m_count            = m_count + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    for (int a = 0; a < 32; a++) begin
      wb_if.ReadRegister1 = 5'(a);
      wb_if.ReadRegister2 = 5'(31 - a);
      #1;
      checks += 2;
      if (wb_if.ReadData1 !== 32'd0) begin
        errors++;
        $display("FAIL reset_rd1[%0d] got %h expected %h", a, wb_if.ReadData1, 32'd0);
      end
      if (wb_if.ReadData2 !== 32'd0) begin
        errors++;
        $display("FAIL reset_rd2[%0d] got %h expected %h", 31 - a, wb_if.ReadData2, 32'd0);
      end
    end
    checks += 3;
    if (wb_if.CommitCount !== 32'd0) begin
      errors++; $display("FAIL reset_count got %h expected %h", wb_if.CommitCount, 32'd0);
    end
    if (wb_if.LastWriteReg !== 5'd0) begin
      errors++; $display("FAIL reset_lastreg got %h expected %h", wb_if.LastWriteReg, 5'd0);
    end
    if (wb_if.LastWriteData !== 32'd0) begin
      errors++; $display("FAIL reset_lastdata got %h expected %h", wb_if.LastWriteData, 32'd0);
    end
  endtask

  task automatic test_alu_write();
    drive(1'b1, 1'b0, 1'b0, 5'd5, 32'h1111_1111, 32'h2222_2222, 32'h0000_1234);
    #1;
    checks++;
    if (wb_if.WriteData !== 32'h0000_1234) begin
      errors++; $display("FAIL alu_wdata got %h expected %h", wb_if.WriteData, 32'h0000_1234);
    end
    tick();
    idle();
    wb_if.ReadRegister1 = 5'd5;
    #1;
    checks += 3;
    if (wb_if.ReadData1 !== 32'h0000_1234) begin
      errors++; $display("FAIL alu_read got %h expected %h", wb_if.ReadData1, 32'h0000_1234);
    end
    if (wb_if.LastWriteReg !== 5'd5) begin
      errors++; $display("FAIL alu_lastreg got %h expected %h", wb_if.LastWriteReg, 5'd5);
    end
    if (wb_if.CommitCount !== 32'd1) begin
      errors++; $display("FAIL alu_count got %h expected %h", wb_if.CommitCount, 32'd1);
    end
  endtask

  task automatic test_jal();
    drive(1'b0, 1'b1, 1'b0, 5'd7, 32'h0040_0010, 32'h3333_3333, 32'h4444_4444);
    #1;
    checks++;
    if (wb_if.WriteData !== 32'h0040_0010) begin
      errors++; $display("FAIL jal_wdata got %h expected %h", wb_if.WriteData, 32'h0040_0010);
    end
    tick();
    idle();
    wb_if.ReadRegister1 = 5'd31;
    wb_if.ReadRegister2 = 5'd7;
    #1;
    checks += 4;
    if (wb_if.ReadData1 !== 32'h0040_0010) begin
      errors++; $display("FAIL jal_r31 got %h expected %h", wb_if.ReadData1, 32'h0040_0010);
    end
    if (wb_if.ReadData2 !== 32'd0) begin
      errors++; $display("FAIL jal_r7 got %h expected %h", wb_if.ReadData2, 32'd0);
    end
    if (wb_if.LastWriteReg !== 5'd31) begin
      errors++; $display("FAIL jal_lastreg got %h expected %h", wb_if.LastWriteReg, 5'd31);
    end
    if (wb_if.CommitCount !== 32'd2) begin
      errors++; $display("FAIL jal_count got %h expected %h", wb_if.CommitCount, 32'd2);
    end
  endtask

  task automatic test_reg0();
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'hFFFF_FFFF);
    tick();
    idle();
    wb_if.ReadRegister1 = 5'd0;
    wb_if.ReadRegister2 = 5'd0;
    #1;
    checks += 4;
    if (wb_if.ReadData1 !== 32'd0) begin
      errors++; $display("FAIL r0_rd1 got %h expected %h", wb_if.ReadData1, 32'd0);
    end
    if (wb_if.ReadData2 !== 32'd0) begin
      errors++; $display("FAIL r0_rd2 got %h expected %h", wb_if.ReadData2, 32'd0);
    end
    if (wb_if.CommitCount !== 32'd2) begin
      errors++; $display("FAIL r0_count got %h expected %h", wb_if.CommitCount, 32'd2);
    end
    if (wb_if.LastWriteData !== 32'h0040_0010) begin
      errors++; $display("FAIL r0_lastdata got %h expected %h", wb_if.LastWriteData, 32'h0040_0010);
    end
  endtask

  task automatic test_same_cycle_read();
    logic [31:0] exp_now;
`ifdef WB_BYPASS_EN
    exp_now = 32'hDEAD_BEEF;
`else
    exp_now = 32'd0;
`endif
    drive(1'b1, 1'b0, 1'b1, 5'd9, 32'h5555_5555, 32'hDEAD_BEEF, 32'h6666_6666);
    wb_if.ReadRegister1 = 5'd9;
    wb_if.ReadRegister2 = 5'd9;
    #1;
    checks += 3;
    if (wb_if.WriteData !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL same_wdata got %h expected %h", wb_if.WriteData, 32'hDEAD_BEEF);
    end
    if (wb_if.ReadData1 !== exp_now) begin
      errors++; $display("FAIL same_rd1 got %h expected %h", wb_if.ReadData1, exp_now);
    end
    if (wb_if.ReadData2 !== exp_now) begin
      errors++; $display("FAIL same_rd2 got %h expected %h", wb_if.ReadData2, exp_now);
    end
    tick();
    idle();
    #1;
    checks++;
    if (wb_if.ReadData2 !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL same_next got %h expected %h", wb_if.ReadData2, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_random();
    logic [4:0] rd;
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      rd = 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0), 1'($urandom),
            rd, $urandom, $urandom, $urandom);
      wb_if.ReadRegister1 = ($urandom_range(0, 2) == 0) ? exp_dest() : 5'($urandom_range(0, 31));
      wb_if.ReadRegister2 = 5'($urandom_range(0, 31));
      #1;
      checks += 3;
      if (wb_if.WriteData !== exp_wdata()) begin
        errors++; $display("FAIL rnd_wdata[%0d] got %h expected %h", n, wb_if.WriteData, exp_wdata());
      end
      if (wb_if.ReadData1 !== exp_read(wb_if.ReadRegister1)) begin
        errors++; $display("FAIL rnd_rd1[%0d] got %h expected %h", n, wb_if.ReadData1,
                           exp_read(wb_if.ReadRegister1));
      end
      if (wb_if.ReadData2 !== exp_read(wb_if.ReadRegister2)) begin
        errors++; $display("FAIL rnd_rd2[%0d] got %h expected %h", n, wb_if.ReadData2,
                           exp_read(wb_if.ReadRegister2));
      end
      tick();
      checks += 3;
      if (wb_if.LastWriteReg !== m_last_reg) begin
        errors++; $display("FAIL rnd_lastreg[%0d] got %h expected %h", n, wb_if.LastWriteReg, m_last_reg);
      end
      if (wb_if.LastWriteData !== m_last_data) begin
        errors++; $display("FAIL rnd_lastdata[%0d] got %h expected %h", n, wb_if.LastWriteData, m_last_data);
      end
      if (wb_if.CommitCount !== m_count) begin
        errors++; $display("FAIL rnd_count[%0d] got %h expected %h", n, wb_if.CommitCount, m_count);
      end
    end
    reset = 1'b0;
    idle();
  endtask

  task automatic test_count_wrap();
    force dut.r_commit_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_commit_count;
    m_count = 32'hFFFF_FFFF;
    drive(1'b1, 1'b0, 1'b0, 5'd12, 32'd0, 32'd0, 32'hCAFE_0012);
    tick();
    idle();
    #1;
    checks += 2;
    if (wb_if.CommitCount !== 32'd0) begin
      errors++; $display("FAIL wrap_count got %h expected %h", wb_if.CommitCount, 32'd0);
    end
    if (wb_if.LastWriteReg !== 5'd12) begin
      errors++; $display("FAIL wrap_lastreg got %h expected %h", wb_if.LastWriteReg, 5'd12);
    end
  endtask

  task automatic test_reset_with_commit();
    drive(1'b1, 1'b0, 1'b0, 5'd3, 32'd0, 32'd0, 32'hA5A5_A5A5);
    tick();
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 5'd3, 32'd0, 32'd0, 32'h5A5A_5A5A);
    #1;
    checks++;
    if (wb_if.WriteData !== 32'h5A5A_5A5A) begin
      errors++; $display("FAIL rstc_wdata got %h expected %h", wb_if.WriteData, 32'h5A5A_5A5A);
    end
    tick();
    reset = 1'b0;
    idle();
    wb_if.ReadRegister1 = 5'd3;
    wb_if.ReadRegister2 = 5'd12;
    #1;
    checks += 4;
    if (wb_if.ReadData1 !== 32'd0) begin
      errors++; $display("FAIL rstc_r3 got %h expected %h", wb_if.ReadData1, 32'd0);
    end
    if (wb_if.ReadData2 !== 32'd0) begin
      errors++; $display("FAIL rstc_r12 got %h expected %h", wb_if.ReadData2, 32'd0);
    end
    if (wb_if.CommitCount !== 32'd0) begin
      errors++; $display("FAIL rstc_count got %h expected %h", wb_if.CommitCount, 32'd0);
    end
    if (wb_if.LastWriteReg !== 5'd0) begin
      errors++; $display("FAIL rstc_lastreg got %h expected %h", wb_if.LastWriteReg, 5'd0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle();
    wb_if.ReadRegister1 = 5'd0;
    wb_if.ReadRegister2 = 5'd0;
    test_reset();
    test_alu_write();
    test_jal();
    test_reg0();
    test_same_cycle_read();
    test_random();
    test_count_wrap();
    test_reset_with_commit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
